// File: rtl/clk_prog_tx.sv
// rtl/clk_prog_tx.sv - serial LoadD/LoadM/GO programmer for DCM_CLKGEN programmable clocks
// Optional CLK_PROG_PLL_RESET_EN adds a pll_reset pulse and a second lock wait before done.
module clk_prog_tx #(
    parameter int PROGCLK_DIV = 4,
    parameter int TIMEOUT     = 4096,
    parameter int GAP         = 2,
    parameter int RST_CYCLES  = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic [7:0] m_minus1,
    input  logic [7:0] d_minus1,
    input  logic       progdone_inv,
    output logic [3:0] progen,
    output logic       progdata,
    output logic       progclk,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       pll_reset
);
    localparam int FRAME   = 10;
    localparam int HALF    = PROGCLK_DIV / 2;
    localparam int DIV_W   = $clog2(PROGCLK_DIV);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int CNT_MAX = (RST_CYCLES > FRAME + GAP) ? RST_CYCLES : FRAME + GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_LOAD_D,
        S_GAP_D,
        S_LOAD_M,
        S_GAP_M,
        S_GO,
        S_WAIT_HI,
        S_WAIT_LO,
`ifdef CLK_PROG_PLL_RESET_EN
        S_PLL_RST,
        S_PLL_WAIT,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               pclk_q, pclk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [1:0]         sel_q, sel_d;
    logic [7:0]         m_q, m_d;
    logic [7:0]         d_q, d_d;
    logic               err_q, err_d;
    logic               sync1_q, sync2_q;
    logic               tick, tmo_hit, busy_d;
    logic [2:0]         bit_idx;
    logic [3:0]         sel_oh;

    assign bit_idx = 3'(cnt_q - CNT_W'(2));
    assign sel_oh  = 4'b0001 << sel_q;
    assign progclk = pclk_q;
    assign err     = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        sel_d     = sel_q;
        m_d       = m_q;
        d_d       = d_q;
        err_d     = err_q;
        div_d     = '0;
        pclk_d    = 1'b0;
        progen    = 4'b0000;
        progdata  = 1'b0;
        done      = 1'b0;
        pll_reset = 1'b0;
        busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
        tick      = busy && (div_q == DIV_W'(PROGCLK_DIV - 1));
        tmo_hit   = tick && (tmo_q == TMO_W'(TIMEOUT - 1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRE;
                    sel_d   = sel;
                    m_d     = m_minus1;
                    d_d     = d_minus1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (tick) begin
                    state_d = S_LOAD_D;
                    cnt_d   = '0;
                end
            end
            S_LOAD_D: begin
                progen   = sel_oh;
                progdata = (cnt_q == CNT_W'(0)) ? 1'b1 :
                           (cnt_q == CNT_W'(1)) ? 1'b0 : d_q[bit_idx];
                if (tick) begin
                    if (cnt_q == CNT_W'(FRAME - 1)) begin
                        state_d = S_GAP_D;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAP_D: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        state_d = S_LOAD_M;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_M: begin
                progen   = sel_oh;
                progdata = (cnt_q < CNT_W'(2)) ? 1'b1 : m_q[bit_idx];
                if (tick) begin
                    if (cnt_q == CNT_W'(FRAME - 1)) begin
                        state_d = S_GAP_M;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAP_M: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        state_d = S_GO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GO: begin
                progen = sel_oh;
                if (tick) begin
                    state_d = S_WAIT_HI;
                    tmo_d   = '0;
                end
            end
            // One timeout budget spans both halves of the lock handshake.
            S_WAIT_HI: begin
                if (tick) tmo_d = tmo_q + TMO_W'(1);
                if (sync2_q) state_d = S_WAIT_LO;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_WAIT_LO: begin
                if (tick) tmo_d = tmo_q + TMO_W'(1);
                if (!sync2_q) begin
`ifdef CLK_PROG_PLL_RESET_EN
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
`else
                    state_d = S_DONE;
`endif
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
`ifdef CLK_PROG_PLL_RESET_EN
            S_PLL_RST: begin
                pll_reset = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_PLL_WAIT;
                    tmo_d   = '0;
                end
            end
            S_PLL_WAIT: begin
                if (tick) tmo_d = tmo_q + TMO_W'(1);
                if (!sync2_q) state_d = S_DONE;
                else if (tmo_hit) state_d = S_ERR;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERR) err_d = 1'b1;

        // Divider restarts on acceptance so the first tick is a full period later.
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
        if ((state_q != S_IDLE) && busy_d) begin
            div_d  = tick ? '0 : div_q + DIV_W'(1);
            pclk_d = (div_d >= DIV_W'(HALF));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            pclk_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            sel_q   <= '0;
            m_q     <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            sel_q   <= sel_d;
            m_q     <= m_d;
            d_q     <= d_d;
            err_q   <= err_d;
            sync1_q <= progdone_inv;
            sync2_q <= sync1_q;
        end
    end
endmodule

// File: tb/tb_clk_prog_tx.sv
// tb/tb_clk_prog_tx.sv - randomized bench for clk_prog_tx with a behavioural clocks-block model
module tb_clk_prog_tx;
    localparam int DIV  = 4;
    localparam int TMO  = 64;
    localparam int GAPN = 2;
    localparam int RSTC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [7:0] m = 8'd0;
    logic [7:0] d = 8'd0;
    logic       progdone_inv = 1'b0;
    logic [3:0] progen;
    logic       progdata, progclk, busy, done, err, pll_reset;

    clk_prog_tx #(.PROGCLK_DIV(DIV), .TIMEOUT(TMO), .GAP(GAPN), .RST_CYCLES(RSTC)) dut (
        .CLK(clk), .RESET(rst), .start(start), .sel(sel), .m_minus1(m), .d_minus1(d),
        .progdone_inv(progdone_inv), .progen(progen), .progdata(progdata), .progclk(progclk),
        .busy(busy), .done(done), .err(err), .pll_reset(pll_reset)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Clocks-block model and observation state
    bit         armed = 0;
    logic       prev_pc = 1'b0;
    logic [4:0] stream[$];
    logic [1:0] cur_sel;
    int first_pe_cyc, go_end_cyc, drop_cyc, drop2_cyc, err_cyc, done_cyc;
    int done_cnt, busy_cnt, falls, pll_cnt, lock_ticks, start_cyc;
    bit go_seen, dropped, pll_seen, drop2, never_lock, bad_sel;

    task automatic step();
        @(negedge clk);
        if (armed) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err && err_cyc < 0) err_cyc = cyc;
            if ((progen & ~(4'b0001 << cur_sel)) != 4'b0000) bad_sel = 1;
            if (progen != 4'b0000 && first_pe_cyc < 0) first_pe_cyc = cyc;
            if (progclk && !prev_pc && stream.size() < 26 && (progen != 4'b0000 || stream.size() > 0))
                stream.push_back({progen, progdata});
            if (stream.size() >= 25 && !go_seen) begin
                go_seen = 1;
                progdone_inv = 1'b1;
            end
            if (go_seen && progen == 4'b0000 && go_end_cyc < 0) go_end_cyc = cyc;
            if (go_seen && !dropped && !progclk && prev_pc) begin
                falls++;
                if (falls == lock_ticks && !never_lock) begin
                    progdone_inv = 1'b0;
                    dropped = 1;
                    drop_cyc = cyc;
                end
            end
            if (pll_reset) begin
                pll_cnt++;
                if (!pll_seen) begin
                    pll_seen = 1;
                    progdone_inv = 1'b1;
                    falls = 0;
                end
            end
            if (pll_seen && !drop2 && !progclk && prev_pc) begin
                falls++;
                if (falls == 10) begin
                    progdone_inv = 1'b0;
                    drop2 = 1;
                    drop2_cyc = cyc;
                end
            end
        end
        prev_pc = progclk;
    endtask

    task automatic arm(input logic [1:0] s, input int lt, input bit nl);
        stream.delete();
        first_pe_cyc = -1; go_end_cyc = -1; drop_cyc = -1; drop2_cyc = -1;
        err_cyc = -1; done_cyc = -1;
        done_cnt = 0; busy_cnt = 0; falls = 0; pll_cnt = 0;
        go_seen = 0; dropped = 0; pll_seen = 0; drop2 = 0; bad_sel = 0;
        lock_ticks = lt; never_lock = nl; cur_sel = s;
        progdone_inv = 1'b0;
        armed = 1;
    endtask

    task automatic run_req(input logic [1:0] s, input logic [7:0] dd, input logic [7:0] mm,
                           input int lt, input bit nl, input bit mid);
        logic [4:0] exp_q[$];
        logic [3:0] oh;
        int t;
        bit mid_done;
        arm(s, lt, nl);
        sel = s; d = dd; m = mm; start = 1'b1; start_cyc = cyc;
        step();
        start = 1'b0;
        check_eq("busy_on_accept", busy, 1);
        check_eq("err_clear_on_accept", err, 0);
        t = 0;
        mid_done = 0;
        while (busy && t < 20000) begin
            step();
            t++;
            if (mid && !mid_done && stream.size() == 15) begin
                start = 1'b1; sel = ~s; d = ~dd; m = ~mm;
                mid_done = 1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("busy_fall_bound", (t < 20000), 1);
        step();
        step();
        armed = 0;

        oh = 4'b0001 << s;
        exp_q.push_back({oh, 1'b1});
        exp_q.push_back({oh, 1'b0});
        for (int i = 0; i < 8; i++) exp_q.push_back({oh, dd[i]});
        for (int i = 0; i < GAPN; i++) exp_q.push_back(5'b0);
        exp_q.push_back({oh, 1'b1});
        exp_q.push_back({oh, 1'b1});
        for (int i = 0; i < 8; i++) exp_q.push_back({oh, mm[i]});
        for (int i = 0; i < GAPN; i++) exp_q.push_back(5'b0);
        exp_q.push_back({oh, 1'b0});
        exp_q.push_back(5'b0);
        check_eq("stream_len", stream.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < stream.size(); i++)
            check_eq($sformatf("stream[%0d]", i), stream[i], exp_q[i]);
        check_eq("other_progen_zero", bad_sel, 0);
        check_eq("active_len", go_end_cyc - first_pe_cyc, (10 + GAPN + 10 + GAPN + 1) * DIV);
        check_eq("busy_after", busy, 0);
        if (nl) begin
            check_eq("timeout_err", err, 1);
            check_eq("timeout_no_done", done_cnt, 0);
            check_eq("timeout_time", err_cyc - go_end_cyc, TMO * DIV);
        end else begin
            check_eq("ok_err", err, 0);
            check_eq("done_pulses", done_cnt, 1);
`ifdef CLK_PROG_PLL_RESET_EN
            check_eq("pll_len", pll_cnt, RSTC);
            check_eq("done_after_drop2", (drop2 && done_cyc > drop2_cyc), 1);
`else
            check_eq("pll_tied", pll_cnt, 0);
            check_eq("busy_len", busy_cnt, drop_cyc - start_cyc + 2);
`endif
        end
    endtask

    task automatic reset_mid();
        int t;
        arm(2'd1, 5, 0);
        sel = 2'd1; d = 8'hA5; m = 8'h3C; start = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        while (stream.size() < 6 && t < 500) begin
            step();
            t++;
        end
        check_eq("reach_bit5", (stream.size() >= 6), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_progen", progen, 0);
        check_eq("rst_progclk", progclk, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_progdata", progdata, 0);
        step();
        rst = 1'b0;
        armed = 0;
        step();
    endtask

    initial begin
        repeat (3) step();
        check_eq("reset_progen", progen, 0);
        check_eq("reset_progdata", progdata, 0);
        check_eq("reset_progclk", progclk, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_err", err, 0);
        check_eq("reset_pll", pll_reset, 0);
        rst = 1'b0;
        repeat (2) step();

        run_req(2'd0, 8'd15, 8'd44, 20, 0, 0);
        run_req(2'd2, 8'($urandom), 8'($urandom), 2 + int'($urandom_range(0, 30)), 0, 0);
        run_req(2'd3, 8'($urandom), 8'($urandom), 2 + int'($urandom_range(0, 30)), 0, 1);
        for (int k = 0; k < 4; k++)
            run_req(2'($urandom), 8'($urandom), 8'($urandom), 2 + int'($urandom_range(0, 40)), 0, 0);
        run_req(2'($urandom), 8'($urandom), 8'($urandom), 5, 1, 0);
        run_req(2'($urandom), 8'($urandom), 8'($urandom), 2 + int'($urandom_range(0, 30)), 0, 0);
        reset_mid();
        run_req(2'd1, 8'($urandom), 8'($urandom), 2 + int'($urandom_range(0, 30)), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
